// File: rtl/wb_conv_fabric.sv
// Wishbone fan-out fabric for NO_OF_INSTS convolution accelerators: one
// registered transaction at a time, with broadcast writes, decode errors and a slave timeout.
module wb_conv_fabric #(
    parameter int unsigned NO_OF_INSTS = 4,
    parameter int unsigned SEL_MSB     = 31,
    parameter int unsigned SEL_LSB     = 24,
    parameter int unsigned BASE_SEL    = 32'h30,
    parameter int unsigned BCAST_SEL   = 32'h3F,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_dat_i,
    input  logic [31:0]                 wbs_adr_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic [NO_OF_INSTS-1:0]      s_cyc_o,
    output logic [NO_OF_INSTS-1:0]      s_stb_o,
    output logic                        s_we_o,
    output logic [3:0]                  s_sel_o,
    output logic [31:0]                 s_dat_o,
    output logic [31:0]                 s_adr_o,
    input  logic [NO_OF_INSTS-1:0]      s_ack_i,
    input  logic [32*NO_OF_INSTS-1:0]   s_dat_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state, state_nxt;
    logic [NO_OF_INSTS-1:0] pending;
    logic [CW-1:0]          cnt;
    logic                   err_q;
    logic [31:0]            rd_q;

    logic [31:0]            f, off;
    logic                   claimed, is_uni, is_bcast, dec_err, accept;
    logic [NO_OF_INSTS-1:0] dec_mask, ack_hit, pend_left;
    logic                   tc;
    logic [31:0]            ack_dat;

    always_comb begin
        f        = 32'(wbs_adr_i[SEL_MSB:SEL_LSB]);
        off      = f - BASE_SEL;
        claimed  = (f >= BASE_SEL) && (f <= BCAST_SEL);
        is_uni   = off < NO_OF_INSTS;
        is_bcast = (f == BCAST_SEL) && wbs_we_i;
        dec_err  = !is_uni && !is_bcast;
        accept   = wbs_cyc_i && wbs_stb_i && claimed;
        dec_mask = '0;
        if (is_uni)
            dec_mask = NO_OF_INSTS'(1) << off;
        else if (is_bcast)
            dec_mask = '1;
    end

    // Terminal count fires on the cycle whose increment would reach TIMEOUT.
    always_comb begin
        ack_hit   = pending & s_ack_i;
        pend_left = pending & ~s_ack_i;
        tc        = (cnt == CW'(TIMEOUT - 1));
        ack_dat   = '0;
        for (int unsigned i = 0; i < NO_OF_INSTS; i++)
            if (ack_hit[i])
                ack_dat = s_dat_i[32*i +: 32];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = dec_err ? RESP : REQ;
            REQ: begin
                if (!wbs_cyc_i)
                    state_nxt = IDLE;
                else if (pend_left == '0 || tc)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state == RESP);
        err_o     = (state == RESP) && err_q;
        busy_o    = (state != IDLE);
        wbs_dat_o = '0;
        if (state == RESP)
            wbs_dat_o = err_q ? ERR_DATA : (s_we_o ? '0 : rd_q);
        s_cyc_o   = (state == REQ) ? pending : '0;
        s_stb_o   = (state == REQ) ? pending : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pending <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            s_we_o  <= 1'b0;
            s_sel_o <= '0;
            s_dat_o <= '0;
            s_adr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_we_o  <= wbs_we_i;
                        s_sel_o <= wbs_sel_i;
                        s_dat_o <= wbs_dat_i;
                        s_adr_o <= wbs_adr_i;
                        pending <= dec_mask;
                        cnt     <= '0;
                        err_q   <= dec_err;
                        rd_q    <= '0;
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        pending <= '0;
                    end else begin
                        if (!s_we_o && ack_hit != '0)
                            rd_q <= ack_dat;
                        // A final ack on the terminal-count cycle completes normally.
                        if (pend_left == '0) begin
                            pending <= '0;
                        end else if (tc) begin
                            pending <= '0;
                            err_q   <= 1'b1;
                        end else begin
                            pending <= pend_left;
                            cnt     <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_conv_fabric.sv
// Directed self-checking bench for wb_conv_fabric (4 instances, TIMEOUT = 8).
module tb_wb_conv_fabric;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic         wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = '0;
    logic [31:0]  wbs_dat_i = '0, wbs_adr_i = '0;
    logic         wbs_ack_o, err_o, busy_o, s_we_o;
    logic [31:0]  wbs_dat_o, s_dat_o, s_adr_o;
    logic [3:0]   s_cyc_o, s_stb_o, s_sel_o;
    logic [3:0]   s_ack_i = '0;
    logic [127:0] s_dat_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_conv_fabric #(.NO_OF_INSTS(4), .TIMEOUT(8)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .err_o(err_o), .busy_o(busy_o),
        .s_cyc_o  (s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_dat_o  (s_dat_o), .s_adr_o(s_adr_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a;    wbs_dat_i = d;    wbs_sel_i = 4'hF;
    endtask

    task automatic idle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    initial begin
        logic [31:0] err_addr [2];
        err_addr[0] = 32'h3500_0000;
        err_addr[1] = 32'h3F00_0000;

        tick(); tick();
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_cyc", s_cyc_o, 0);
        wb_rst_i = 1'b0;

        // Unicast read, instance 2, registered slave ack
        req(1'b0, 32'h3200_0010, 32'h0);
        tick();
        chk("uni_stb", s_stb_o, 4'b0100);
        chk("uni_cyc", s_cyc_o, 4'b0100);
        chk("uni_busy", busy_o, 1);
        chk("uni_adr", s_adr_o, 32'h3200_0010);
        tick();
        chk("uni_noack_early", wbs_ack_o, 0);
        s_ack_i = 4'b0100; s_dat_i[64 +: 32] = 32'h1234_5678;
        tick();
        chk("uni_ack", wbs_ack_o, 1);
        chk("uni_dat", wbs_dat_o, 32'h1234_5678);
        chk("uni_err", err_o, 0);
        chk("uni_stb_drop", s_stb_o, 0);
        s_ack_i = '0; idle();
        tick();
        chk("uni_ack_1cyc", wbs_ack_o, 0);
        chk("uni_dat_zero", wbs_dat_o, 0);
        chk("uni_idle", busy_o, 0);

        // Broadcast write, acks 1/2/3/5 cycles after strobe
        req(1'b1, 32'h3F00_0004, 32'hA5A5_0001);
        tick();
        chk("bc_stb", s_stb_o, 4'hF);
        chk("bc_sdat", s_dat_o, 32'hA5A5_0001);
        chk("bc_we", s_we_o, 1);
        tick(); s_ack_i = 4'b0001;
        tick(); chk("bc_stb_a0", s_stb_o, 4'b1110); s_ack_i = 4'b0010;
        tick(); chk("bc_stb_a1", s_stb_o, 4'b1100); s_ack_i = 4'b0100;
        tick(); chk("bc_stb_a2", s_stb_o, 4'b1000); s_ack_i = 4'b0000;
        tick();
        chk("bc_stb_wait", s_stb_o, 4'b1000);
        chk("bc_noack", wbs_ack_o, 0);
        s_ack_i = 4'b1000;
        tick();
        chk("bc_ack", wbs_ack_o, 1);
        chk("bc_dat", wbs_dat_o, 0);
        chk("bc_err", err_o, 0);
        chk("bc_stb_done", s_stb_o, 0);
        s_ack_i = '0; idle();
        tick();
        chk("bc_single_ack", wbs_ack_o, 0);
        chk("bc_idle", busy_o, 0);

        // Decode errors: hole in window and broadcast read
        for (int i = 0; i < 2; i++) begin
            req(1'b0, err_addr[i], 32'h0);
            tick();
            chk("derr_ack", wbs_ack_o, 1);
            chk("derr_err", err_o, 1);
            chk("derr_dat", wbs_dat_o, 32'hDEAD_BEEF);
            chk("derr_stb", s_stb_o, 0);
            idle();
            tick();
            chk("derr_ack_drop", wbs_ack_o, 0);
        end

        // Unclaimed address: ignored
        req(1'b0, 32'h2000_0000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("unclaimed_ack", wbs_ack_o, 0);
            chk("unclaimed_busy", busy_o, 0);
        end
        idle();

        // Timeout: instance 1 never acks
        tick();
        req(1'b0, 32'h3100_0000, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_wait", wbs_ack_o, 0);
        end
        tick();
        chk("to_ack", wbs_ack_o, 1);
        chk("to_err", err_o, 1);
        chk("to_dat", wbs_dat_o, 32'hDEAD_BEEF);
        idle();
        tick();
        chk("to_idle", busy_o, 0);

        // Ack on the terminal-count cycle wins
        req(1'b0, 32'h3100_0000, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("tc_wait", wbs_ack_o, 0);
        end
        tick();
        chk("tc_stb", s_stb_o, 4'b0010);
        s_ack_i = 4'b0010; s_dat_i[32 +: 32] = 32'hCAFE_0001;
        tick();
        chk("tc_ack", wbs_ack_o, 1);
        chk("tc_err", err_o, 0);
        chk("tc_dat", wbs_dat_o, 32'hCAFE_0001);
        s_ack_i = '0; idle();
        tick();

        // Reset while instance 3 is pending
        req(1'b0, 32'h3300_0000, 32'h0);
        tick();
        chk("rq_stb", s_stb_o, 4'b1000);
        wb_rst_i = 1'b1;
        tick();
        chk("rq_ack", wbs_ack_o, 0);
        chk("rq_stb_rst", s_stb_o, 0);
        chk("rq_busy", busy_o, 0);
        chk("rq_adr", s_adr_o, 0);
        chk("rq_dat", wbs_dat_o, 0);
        chk("rq_errflag", err_o, 0);
        wb_rst_i = 1'b0;
        req(1'b1, 32'h3300_0008, 32'h0000_BEEF);
        tick();
        chk("rq2_stb", s_stb_o, 4'b1000);
        chk("rq2_sdat", s_dat_o, 32'h0000_BEEF);
        s_ack_i = 4'b1000;
        tick();
        chk("rq2_ack", wbs_ack_o, 1);
        chk("rq2_err", err_o, 0);
        chk("rq2_dat", wbs_dat_o, 0);
        s_ack_i = '0; idle();
        tick();
        chk("rq2_idle", busy_o, 0);

        // Spurious ack ignored, then cyc abort
        req(1'b0, 32'h3100_0000, 32'h0);
        tick();
        chk("sp_stb", s_stb_o, 4'b0010);
        s_ack_i = 4'b0001; s_dat_i[0 +: 32] = 32'h1111_1111;
        tick();
        chk("sp_stb_held", s_stb_o, 4'b0010);
        chk("sp_noack", wbs_ack_o, 0);
        s_ack_i = '0; wbs_cyc_i = 1'b0;
        tick();
        chk("ab_stb", s_stb_o, 0);
        chk("ab_cyc", s_cyc_o, 0);
        chk("ab_busy", busy_o, 0);
        chk("ab_noack", wbs_ack_o, 0);
        wbs_stb_i = 1'b0;
        tick();
        chk("ab_noack2", wbs_ack_o, 0);

        // Instance 0 read after abort
        req(1'b0, 32'h3000_0000, 32'h0);
        tick();
        chk("i0_stb", s_stb_o, 4'b0001);
        s_ack_i = 4'b0001;
        tick();
        chk("i0_ack", wbs_ack_o, 1);
        chk("i0_dat", wbs_dat_o, 32'h1111_1111);
        s_ack_i = '0; idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
